puf_eval_ctrl: RTL and testbench
================================

// Module: puf_eval_ctrl
// PURPOSE
//   Sequences one PUF evaluation on the puf_super macro: serially loads a 128-bit challenge into the
//   challenge shift register, holds the selected PUF in reset, releases it, waits for settling, samples
//   the synchronised PUF output and returns a 1-bit response with a done pulse. Sits between the
//   host/wishbone register block and puf_super; it is the only driver of si, reset, puf_sel and length.
// PARAMETERS
//   CHAL_BITS   128  challenge length; bits shifted per load
//   RESET_CYC   4    cycles puf_reset is held high before release (>=1)
//   SETTLE_CYC  16   cycles after release before sampling (>=3, covers 2-flop sync)
//   NSAMP       8    evaluations voted per challenge when PUF_EVAL_MAJORITY_EN is defined (>=1)
// PORTS
//   clk         in   1          system clock; also clocks ChalShiftReg
//   rstn        in   1          asynchronous active-low reset
//   start       in   1          request evaluation; accepted only in IDLE
//   abort       in   1          cancel in-flight evaluation
//   challenge   in   CHAL_BITS  challenge; captured on accepted start
//   sel_in      in   2          PUF select (00,01 arbiter; 10,11 n-type); captured on start
//   length_in   in   2          delay-line length code; captured on start
//   busy        out  1          high from accepted start until DONE cycle inclusive
//   done        out  1          one-cycle pulse, response valid
//   response    out  1          evaluation result; held until next accepted start
//   sr_en       out  1          shift enable to challenge-register clock gate
//   sr_si       out  1          serial challenge data
//   puf_reset   out  1          high = PUF held in reset; low = race running
//   puf_sel     out  2          registered sel_in
//   length      out  2          registered length_in
//   puf_out     in   1          PUF output (async to clk)
// BEHAVIOUR
//   - Reset values: busy=0, done=0, response=0, sr_en=0, sr_si=0, puf_reset=1, puf_sel=0, length=0.
//     FSM=IDLE, all counters 0.
//   - puf_out passes through a 2-flop synchroniser, always clocked; the sampled value is the sync output.
//   - FSM states: IDLE, LOAD, RST, SETTLE, SAMPLE, DONE.
//     IDLE: start=1 -> capture challenge/sel/length, response<=0, go LOAD.
//     LOAD: CHAL_BITS cycles; sr_en=1; sr_si=shadow[CHAL_BITS-1], shadow shifts left (MSB first).
//           Exits to RST.
//     RST: puf_reset=1 for RESET_CYC cycles -> SETTLE.
//     SETTLE: puf_reset=0 for SETTLE_CYC cycles -> SAMPLE.
//     SAMPLE: 1 cycle, capture synced puf_out, puf_reset=1. Next state is RST if more samples are
//             pending, else DONE.
//     DONE: done=1 for 1 cycle, response valid -> IDLE.
//   - sr_en=0 and sr_si=0 in every state except LOAD. puf_reset=0 only in SETTLE.
//   - Latency: start accepted at edge E0; done high in cycle CHAL_BITS+RESET_CYC+SETTLE_CYC+2
//     (defaults: 150).
//   - puf_sel/length change only on accepted start, so the output mux is stable for the whole run.
//   - start while busy: ignored, no queueing. start in the DONE cycle: ignored.
//   - abort (any non-IDLE state):
//       next cycle IDLE, puf_reset=1, sr_en=0, busy=0, no done pulse, response unchanged.
//       abort has priority over start in the same cycle.
//   - abort in IDLE: no effect. Reset mid-operation: all outputs return to reset values immediately
//     (async assert), synchronous release.
//   - Counters are sized $clog2(max+1); terminal-count compare, no wrap beyond max.
// CONFIGURATION
//   PUF_EVAL_MAJORITY_EN defined:
//     - RST/SETTLE/SAMPLE repeats NSAMP times per challenge; the challenge is loaded once.
//     - A ones counter of $clog2(NSAMP+1) bits accumulates samples.
//     - response = (ones > NSAMP/2); on a tie (even NSAMP) response=0.
//     - Latency: CHAL_BITS + NSAMP*(RESET_CYC+SETTLE_CYC+1) + 1 (defaults: 297).
//   Undefined: NSAMP is ignored, a single sample is taken, response = that sample,
//     and no ones counter is built.
// TESTING
//   1 Reset: rstn=0 mid-LOAD -> puf_reset=1, sr_en=0, busy=0 same cycle; after release IDLE.
//   2 Load: challenge=128'h8000...0001, start -> sr_si=1 on 1st LOAD cycle, 0 x126, 1 on 128th;
//     sr_en high exactly 128 cycles.
//   3 Single eval (macro off): model puf_out=1 during SETTLE, sel_in=2'b10 -> done at cycle 150,
//     response=1, puf_sel=2'b10 throughout.
//   4 Majority (macro on, NSAMP=8): puf_out=1 for 5 of 8 evaluations -> response=1 at cycle 297;
//     repeat with 4 of 8 -> response=0 (tie).
//   5 abort in SETTLE -> IDLE next cycle, no done, response keeps prior value;
//     abort+start in the same cycle -> abort wins.
//   6 start pulsed during busy -> ignored; exactly one done; puf_reset low only during SETTLE windows.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences challenge load, PUF reset/settle/sample and response return (majority vote under PUF_EVAL_MAJORITY_EN)
module puf_eval_ctrl #(
  parameter int CHAL_BITS  = 128,
  parameter int RESET_CYC  = 4,
  parameter int SETTLE_CYC = 16,
  parameter int NSAMP      = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAL_BITS-1:0] challenge,
  input  logic [1:0]           sel_in,
  input  logic [1:0]           length_in,
  output logic                 busy,
  output logic                 done,
  output logic                 response,
  output logic                 sr_en,
  output logic                 sr_si,
  output logic                 puf_reset,
  output logic [1:0]           puf_sel,
  output logic [1:0]           length,
  input  logic                 puf_out
);
  typedef enum logic [2:0] {IDLE, LOAD, RST, SETTLE, SAMPLE, DONE} state_t;
  localparam int CNT_MAX = (CHAL_BITS > RESET_CYC) ?
                           ((CHAL_BITS > SETTLE_CYC) ? CHAL_BITS : SETTLE_CYC) :
                           ((RESET_CYC > SETTLE_CYC) ? RESET_CYC : SETTLE_CYC);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LOAD_LAST   = CW'(CHAL_BITS - 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
`ifdef PUF_EVAL_MAJORITY_EN
  localparam int SW = $clog2(NSAMP + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(NSAMP - 1);
  localparam logic [SW-1:0] HALF      = SW'(NSAMP / 2);
  logic [SW-1:0] samp_q, samp_d, ones_q, ones_d;
`endif
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAL_BITS-1:0] shadow_q, shadow_d;
  logic                 response_q, response_d;
  logic [1:0]           puf_sel_q, puf_sel_d, length_q, length_d;
  logic [1:0]           sync_q, sync_d;
  // puf_out is asynchronous; the 2-flop chain runs regardless of FSM state
  always_comb sync_d = {sync_q[0], puf_out};
  // next-state, counters and captured run parameters
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    response_d = response_q;
    puf_sel_d  = puf_sel_q;
    length_d   = length_q;
`ifdef PUF_EVAL_MAJORITY_EN
    samp_d     = samp_q;
    ones_d     = ones_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d    = LOAD;
        cnt_d      = '0;
        shadow_d   = challenge;
        puf_sel_d  = sel_in;
        length_d   = length_in;
        response_d = 1'b0;
`ifdef PUF_EVAL_MAJORITY_EN
        samp_d     = '0;
        ones_d     = '0;
`endif
      end
      LOAD: begin
        shadow_d = {shadow_q[CHAL_BITS-2:0], 1'b0};
        state_d  = (cnt_q == LOAD_LAST) ? RST : LOAD;
        cnt_d    = (cnt_q == LOAD_LAST) ? '0 : cnt_q + 1'b1;
      end
      RST: begin
        state_d = (cnt_q == RST_LAST) ? SETTLE : RST;
        cnt_d   = (cnt_q == RST_LAST) ? '0 : cnt_q + 1'b1;
      end
      SETTLE: begin
        state_d = (cnt_q == SETTLE_LAST) ? SAMPLE : SETTLE;
        cnt_d   = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
      end
`ifdef PUF_EVAL_MAJORITY_EN
      SAMPLE: begin
        ones_d  = ones_q + SW'(sync_q[1]);
        state_d = (samp_q == SAMP_LAST) ? DONE : RST;
        samp_d  = (samp_q == SAMP_LAST) ? samp_q : samp_q + 1'b1;
        response_d = (samp_q == SAMP_LAST) ? (ones_d > HALF) : response_q;
      end
`else
      SAMPLE: begin
        response_d = sync_q[1];
        state_d    = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      cnt_d      = '0;
      response_d = response_q;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      response_q <= 1'b0;
      puf_sel_q  <= 2'b00;
      length_q   <= 2'b00;
      sync_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      response_q <= response_d;
      puf_sel_q  <= puf_sel_d;
      length_q   <= length_d;
      sync_q     <= sync_d;
    end
  end
`ifdef PUF_EVAL_MAJORITY_EN
  // vote accumulation across repeated samples of one challenge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      samp_q <= '0;
      ones_q <= '0;
    end else begin
      samp_q <= samp_d;
      ones_q <= ones_d;
    end
  end
`endif
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign sr_en     = state_q == LOAD;
  assign sr_si     = (state_q == LOAD) & shadow_q[CHAL_BITS-1];
  assign puf_reset = state_q != SETTLE;
  assign response  = response_q;
  assign puf_sel   = puf_sel_q;
  assign length    = length_q;
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: directed scoreboard bench for puf_eval_ctrl (majority mode when PUF_EVAL_MAJORITY_EN is defined)
module tb_puf_eval_ctrl;
`ifdef PUF_EVAL_MAJORITY_EN
  localparam int NS  = 8;
  localparam int LAT = 297;
`else
  localparam int NS  = 1;
  localparam int LAT = 150;
`endif
  logic         clk = 0, rstn = 1, start = 0, abort = 0, puf_out = 0;
  logic [127:0] challenge = '0;
  logic [1:0]   sel_in = '0, length_in = '0;
  logic         busy, done, response, sr_en, sr_si, puf_reset;
  logic [1:0]   puf_sel, length;
  int           checks = 0, errors = 0;
  logic         exp_q[$];

  puf_eval_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .challenge(challenge),
    .sel_in(sel_in), .length_in(length_in), .busy(busy), .done(done), .response(response),
    .sr_en(sr_en), .sr_si(sr_si), .puf_reset(puf_reset), .puf_sel(puf_sel), .length(length),
    .puf_out(puf_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic exp_resp(input logic [7:0] p);
    int ones = 0;
    for (int i = 0; i < NS; i++) ones += int'(p[i]);
    return (NS == 1) ? p[0] : (ones > NS / 2);
  endfunction

  task automatic run_eval(input logic [127:0] ch, input logic [1:0] s, input logic [1:0] l,
                          input logic [7:0] p, input int abort_at, input int start_again_at);
    int           dones = 0, en_cnt = 0, low_cnt = 0, win = 0;
    logic [127:0] sh = '0;
    logic         prev_rst = 1'b1;
    logic         sel_ok = 1'b1, si_ok = 1'b1;
    @(negedge clk);
    challenge = ch; sel_in = s; length_in = l; start = 1; puf_out = 0;
    if (abort_at < 0) exp_q.push_back(exp_resp(p));
    @(posedge clk);
    for (int cyc = 1; cyc <= LAT + 5; cyc++) begin
      @(negedge clk);
      start = (cyc == start_again_at);
      abort = (cyc == abort_at);
      sel_in = ~s; length_in = ~l; challenge = ~ch;
      if (!prev_rst && puf_reset) win++;
      prev_rst = puf_reset;
      puf_out = !puf_reset && win < 8 && p[win];
      if (!puf_reset) low_cnt++;
      if (sr_en) begin en_cnt++; sh = {sh[126:0], sr_si}; end
      else if (sr_si) si_ok = 1'b0;
      if (puf_sel !== s || length !== l) sel_ok = 1'b0;
      if (abort_at > 0 && cyc == abort_at + 1) begin
        chk("abort_busy", busy, 0);
        chk("abort_puf_reset", puf_reset, 1);
        chk("abort_sr_en", sr_en, 0);
      end
      if (done) begin
        dones++;
        chk("latency", cyc, LAT);
        chk("queue_nonempty", exp_q.size(), 1);
        if (exp_q.size() != 0) chk("response", response, exp_q.pop_front());
      end
    end
    start = 0; abort = 0; puf_out = 0;
    chk("idle_after_run", busy, 0);
    chk("sel_len_held", sel_ok, 1);
    chk("sr_si_zero_outside_load", si_ok, 1);
    if (abort_at < 0) begin
      chk("done_count", dones, 1);
      chk("sr_en_cycles", en_cnt, 128);
      chk("shifted_challenge", sh, ch);
      chk("puf_reset_low_cycles", low_cnt, 16 * NS);
    end else begin
      chk("no_done_on_abort", dones, 0);
      chk("resp_after_abort", response, 0);
    end
  endtask

  initial begin
    #2 rstn = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_response", response, 0);
    chk("rst_sr_en", sr_en, 0);
    chk("rst_sr_si", sr_si, 0);
    chk("rst_puf_reset", puf_reset, 1);
    chk("rst_puf_sel", puf_sel, 0);
    chk("rst_length", length, 0);
    rstn = 1;
    @(negedge clk);
    challenge = {128{1'b1}}; sel_in = 2'b11; length_in = 2'b11; start = 1;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    chk("midload_busy", busy, 1);
    chk("midload_sr_en", sr_en, 1);
    rstn = 0;
    #1;
    chk("async_rst_puf_reset", puf_reset, 1);
    chk("async_rst_sr_en", sr_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_puf_sel", puf_sel, 0);
    @(negedge clk);
    rstn = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_done", done, 0);
    run_eval({1'b1, 126'b0, 1'b1}, 2'b10, 2'b01, 8'b1011_0101, -1, -1);
    run_eval(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 2'b01, 2'b10, 8'b0101_0101, -1, -1);
    run_eval(128'hdead_beef_0000_ffff_a5a5_5a5a_c3c3_3c3c, 2'b00, 2'b11, 8'h00, -1, -1);
    run_eval(128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa, 2'b11, 2'b00, 8'hff, -1, -1);
    run_eval(128'hffff_0000_ffff_0000_ffff_0000_ffff_0000, 2'b10, 2'b10, 8'hff, 137, -1);
    run_eval(128'h1, 2'b01, 2'b01, 8'hff, 10, 10);
    run_eval(128'hcafe_f00d_1234_5678_9abc_def0_0f0f_f0f0, 2'b10, 2'b01, 8'hff, -1, 140);
    run_eval(128'h8765_4321_0fed_cba9_1357_9bdf_2468_ace0, 2'b01, 2'b11, 8'b1110_0001, -1, LAT);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
